// File: rtl/chip8_stack_pkg.sv
// Shared types and constants for the CHIP-8 CALL/RET sequencer and Chip8_Stack.
package chip8_stack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POP_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [1:0]  STK_NOP     = 2'b00;
  localparam logic [1:0]  STK_PUSH    = 2'b01;
  localparam logic [1:0]  STK_POP     = 2'b10;

  localparam logic [15:0] OP_RET      = 16'h00EE;
  localparam logic [3:0]  OP_CALL_NIB = 4'h2;

endpackage

// File: rtl/chip8_stack_depth_ctr.sv
// Up/down entry counter for the subroutine stack; saturates at 0 and DEPTH.
module chip8_stack_depth_ctr #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [4:0] count,
  output logic       full,
  output logic       empty
);

  logic [4:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 5'd0;
    end else if (inc && !full) begin
      count_q <= count_q + 5'd1;
    end else if (dec && !empty) begin
      count_q <= count_q - 5'd1;
    end
  end

  assign count = count_q;
  assign full  = (count_q == 5'(DEPTH));
  assign empty = (count_q == 5'd0);

endmodule

// File: rtl/chip8_call_ret_ctrl.sv
// CALL (2NNN) / RET (00EE) sequencer in front of Chip8_Stack.
// Depth is tracked locally so overflow/underflow fail before any stack strobe.
module chip8_call_ret_ctrl
  import chip8_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 12
) (
  input  logic            cpu_clk,
  input  logic            reset,
  input  logic            req,
  input  logic [15:0]     opcode,
  input  logic [PC_W-1:0] pc_in,
  output logic            ready,
  output logic            done,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic            err,
  output logic            err_overflow,
  output logic            err_underflow,
  input  logic            err_clear,
  output logic [1:0]      stk_we,
  output logic [15:0]     stk_wdata,
  input  logic [15:0]     stk_rdata,
  output logic [4:0]      depth
);

  state_t            state_q;
  logic [PC_W-1:0]   target_q;
  logic [PC_W-1:0]   pc_next_q;
  logic [15:0]       wdata_q;
  logic              ovf_q;
  logic              unf_q;

  logic              is_call;
  logic              is_ret;
  logic [PC_W-1:0]   ret_addr;
  logic              full;
  logic              empty;

  assign is_call  = (opcode[15:12] == OP_CALL_NIB);
  assign is_ret   = (opcode == OP_RET);
  assign ret_addr = pc_in + PC_W'(2);

  chip8_stack_depth_ctr #(.DEPTH(DEPTH)) u_depth (
    .clk   (cpu_clk),
    .rst   (reset),
    .inc   (state_q == S_PUSH),
    .dec   (state_q == S_POP),
    .count (depth),
    .full  (full),
    .empty (empty)
  );

  // A same-cycle flag set is written after the clear, so the set wins.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      pc_next_q <= '0;
      wdata_q   <= 16'd0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (err_clear) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (is_call) begin
              if (!full) begin
                target_q <= PC_W'(opcode[11:0]);
                wdata_q  <= 16'(ret_addr);
                state_q  <= S_PUSH;
              end else begin
                ovf_q   <= 1'b1;
                state_q <= S_FAIL;
              end
            end else if (is_ret) begin
              if (!empty) begin
                state_q <= S_POP;
              end else begin
                unf_q   <= 1'b1;
                state_q <= S_FAIL;
              end
            end else begin
              state_q <= S_FAIL;
            end
          end
        end
        S_PUSH: begin
          pc_next_q <= target_q;
          state_q   <= S_DONE;
        end
        S_POP:      state_q <= S_POP_WAIT;
        // Chip8_Stack presents the popped entry one cycle after the strobe.
        S_POP_WAIT: begin
          pc_next_q <= stk_rdata[PC_W-1:0];
          state_q   <= S_DONE;
        end
        S_DONE:     state_q <= S_IDLE;
        S_FAIL:     state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stk_we = STK_NOP;
    case (state_q)
      S_PUSH:  stk_we = STK_PUSH;
      S_POP:   stk_we = STK_POP;
      default: stk_we = STK_NOP;
    endcase
  end

  assign ready         = (state_q == S_IDLE);
  assign done          = (state_q == S_DONE) || (state_q == S_FAIL);
  assign pc_load       = (state_q == S_DONE);
  assign err           = (state_q == S_FAIL);
  assign pc_next       = pc_next_q;
  assign stk_wdata     = wdata_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// Bench for chip8_call_ret_ctrl: reference model feeds a scoreboard checked on done.
module tb_chip8_call_ret_ctrl;

  logic        cpu_clk;
  logic        reset;
  logic        req;
  logic [15:0] opcode;
  logic [11:0] pc_in;
  logic        ready, done, pc_load, err;
  logic [11:0] pc_next;
  logic        err_overflow, err_underflow, err_clear;
  logic [1:0]  stk_we;
  logic [15:0] stk_wdata, stk_rdata;
  logic [4:0]  depth;

  chip8_call_ret_ctrl #(.DEPTH(16), .PC_W(12)) dut (
    .cpu_clk       (cpu_clk),
    .reset         (reset),
    .req           (req),
    .opcode        (opcode),
    .pc_in         (pc_in),
    .ready         (ready),
    .done          (done),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .err           (err),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_clear     (err_clear),
    .stk_we        (stk_we),
    .stk_wdata     (stk_wdata),
    .stk_rdata     (stk_rdata),
    .depth         (depth)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural Chip8_Stack: registered read, data visible the cycle after a pop.
  logic [15:0] bstk [0:31];
  logic [4:0]  bsp;
  always @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      bsp       <= 5'd0;
      stk_rdata <= 16'd0;
    end else if (stk_we == 2'b01) begin
      bstk[bsp] <= stk_wdata;
      bsp       <= bsp + 5'd1;
    end else if (stk_we == 2'b10) begin
      stk_rdata <= bstk[bsp - 5'd1];
      bsp       <= bsp - 5'd1;
    end
  end

  typedef struct {
    logic        pc_load;
    logic        err;
    logic [11:0] pc_next;
    logic [4:0]  depth;
    logic        ovf;
    logic        unf;
    int          lat;
    int          npush;
    int          npop;
    logic [15:0] pushd;
    logic [15:0] wdata;
    int          start;
  } exp_t;

  exp_t        sbq[$];
  logic [11:0] m_stk[$];
  int          m_depth = 0;
  logic        m_ovf = 0, m_unf = 0;
  logic [15:0] m_wdata = 16'd0;

  int          n_push = 0, n_pop = 0, n_bad = 0;
  logic [15:0] push_dat = 16'd0;

  always @(negedge cpu_clk) begin
    if (reset) begin
      n_push = 0; n_pop = 0; n_bad = 0;
    end else begin
      if (stk_we == 2'b01) begin n_push++; push_dat = stk_wdata; end
      if (stk_we == 2'b10) n_pop++;
      if (stk_we == 2'b11) n_bad++;
      if (done) begin
        if (sbq.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_eq("pc_load", 32'(pc_load), 32'(e.pc_load));
          check_eq("err", 32'(err), 32'(e.err));
          if (e.pc_load) check_eq("pc_next", 32'(pc_next), 32'(e.pc_next));
          check_eq("depth", 32'(depth), 32'(e.depth));
          check_eq("err_overflow", 32'(err_overflow), 32'(e.ovf));
          check_eq("err_underflow", 32'(err_underflow), 32'(e.unf));
          check_eq("latency", 32'(cyc - e.start), 32'(e.lat));
          check_eq("push_strobes", 32'(n_push), 32'(e.npush));
          check_eq("pop_strobes", 32'(n_pop), 32'(e.npop));
          check_eq("we_11", 32'(n_bad), 32'd0);
          if (e.npush != 0) check_eq("push_data", 32'(push_dat), 32'(e.pushd));
          check_eq("wdata_hold", 32'(stk_wdata), 32'(e.wdata));
        end
        n_push = 0; n_pop = 0; n_bad = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin @(negedge cpu_clk); n++; end
    if (!ready) check_eq("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic do_req(input logic [15:0] op, input logic [11:0] pc, input logic clr);
    exp_t e;
    logic [11:0] ret;
    int n;
    e = '{pc_load: 1'b0, err: 1'b0, pc_next: 12'd0, depth: 5'd0, ovf: 1'b0, unf: 1'b0,
          lat: 1, npush: 0, npop: 0, pushd: 16'd0, wdata: 16'd0, start: 0};
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (op[15:12] == 4'h2) begin
      if (m_depth < 16) begin
        ret = pc + 12'd2;
        m_stk.push_back(ret);
        m_depth++;
        m_wdata   = {4'h0, ret};
        e.pc_load = 1; e.pc_next = op[11:0]; e.lat = 2; e.npush = 1; e.pushd = m_wdata;
      end else begin
        m_ovf = 1; e.err = 1;
      end
    end else if (op == 16'h00EE) begin
      if (m_depth > 0) begin
        e.pc_next = m_stk.pop_back();
        m_depth--;
        e.pc_load = 1; e.lat = 3; e.npop = 1;
      end else begin
        m_unf = 1; e.err = 1;
      end
    end else begin
      e.err = 1;
    end
    e.depth = 5'(m_depth); e.ovf = m_ovf; e.unf = m_unf; e.wdata = m_wdata;
    wait_ready();
    req = 1'b1; opcode = op; pc_in = pc; err_clear = clr;
    e.start = cyc;
    sbq.push_back(e);
    @(negedge cpu_clk);
    req = 1'b0; err_clear = 1'b0; opcode = 16'h0000;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge cpu_clk); n++; end
    if (sbq.size() != 0) begin
      check_eq("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; opcode = 16'h0; pc_in = 12'h0; err_clear = 1'b0;
    repeat (2) @(negedge cpu_clk);
    reset = 1'b0;
    @(negedge cpu_clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pc_load", 32'(pc_load), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_pc_next", 32'(pc_next), 32'd0);
    check_eq("rst_stk_we", 32'(stk_we), 32'd0);
    check_eq("rst_wdata", 32'(stk_wdata), 32'd0);
    check_eq("rst_depth", 32'(depth), 32'd0);
    check_eq("rst_flags", 32'({err_overflow, err_underflow}), 32'd0);

    // CALL then RET
    do_req(16'h2345, 12'h200, 1'b0);
    do_req(16'h00EE, 12'h350, 1'b0);

    // Nested
    do_req(16'h2340, 12'h200, 1'b0);
    do_req(16'h2400, 12'h344, 1'b0);
    do_req(16'h2500, 12'h400, 1'b0);
    for (int i = 0; i < 3; i++) do_req(16'h00EE, 12'h600, 1'b0);

    // Fill to DEPTH, overflow, drain, underflow
    for (int i = 0; i < 16; i++) do_req(16'h2600 | 16'(i), 12'h100 + 12'(i * 4), 1'b0);
    do_req(16'h2777, 12'h700, 1'b0);
    for (int i = 0; i < 16; i++) do_req(16'h00EE, 12'h610, 1'b0);
    do_req(16'h00EE, 12'h620, 1'b0);

    // Invalid opcode leaves both sticky flags as they are
    do_req(16'h1234, 12'h300, 1'b0);

    // Clear coincident with a new underflow: underflow stays set
    do_req(16'h00EE, 12'h304, 1'b1);

    @(negedge cpu_clk);
    err_clear = 1'b1;
    @(negedge cpu_clk);
    err_clear = 1'b0;
    m_ovf = 0; m_unf = 0;
    check_eq("clear_flags", 32'({err_overflow, err_underflow}), 32'd0);

    // PC wrap
    do_req(16'h2123, 12'hFFE, 1'b0);
    do_req(16'h00EE, 12'h130, 1'b0);

    // Reset while in PUSH with one entry already on the stack
    do_req(16'h2222, 12'h040, 1'b0);
    wait_ready();
    req = 1'b1; opcode = 16'h2777; pc_in = 12'h500;
    @(negedge cpu_clk);
    req = 1'b0; opcode = 16'h0000;
    check_eq("mid_push_strobe", 32'(stk_we), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_stk_we", 32'(stk_we), 32'd0);
    check_eq("mid_rst_depth", 32'(depth), 32'd0);
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    sbq.delete(); m_stk.delete();
    m_depth = 0; m_ovf = 0; m_unf = 0; m_wdata = 16'd0;
    @(negedge cpu_clk);
    reset = 1'b0;
    @(negedge cpu_clk);
    check_eq("post_rst_done", 32'(done), 32'd0);
    do_req(16'h00EE, 12'h500, 1'b0);

    repeat (3) @(negedge cpu_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_call_ret_ctrl.md
Name: chip8_call_ret_ctrl

Overview:
Sequencer that executes CHIP-8 subroutine CALL (2NNN) and RET (00EE) against the existing Chip8_Stack. It accepts one opcode at a time from the CPU, issues push/pop strobes and data to the stack, and returns the next PC. It keeps its own depth counter so overflow and underflow are caught before the stack is touched. It sits between the CPU decode/execute FSM and Chip8_Stack.

Parameters:
DEPTH, 16, maximum stack entries; valid range 1..31.
PC_W, 12, program counter width in bits.

Ports:
cpu_clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  1  CPU request; sampled only while ready=1.
opcode  input  16  instruction accompanying req.
pc_in  input  PC_W  address of the current instruction.
ready  output  1  high in IDLE only.
done  output  1  one-cycle completion pulse.
pc_load  output  1  one-cycle pulse with done on a successful CALL/RET; CPU loads pc_next.
pc_next  output  PC_W  new PC; valid while pc_load=1.
err  output  1  one-cycle pulse with done when a request fails.
err_overflow  output  1  sticky; set by CALL at full depth.
err_underflow  output  1  sticky; set by RET at zero depth.
err_clear  input  1  synchronous clear of both sticky flags.
stk_we  output  2  to Chip8_Stack WE: 00 idle, 01 push, 10 pop.
stk_wdata  output  16  to Chip8_Stack writedata.
stk_rdata  input  16  from Chip8_Stack outdata.
depth  output  5  current entry count, 0..DEPTH.

Behaviour:
- Reset (async, immediate): state IDLE; ready=1; done=pc_load=err=0; pc_next=0; stk_we=00; stk_wdata=0; depth=0; sticky flags 0. Stack contents are not cleared. With depth=0 they are unreachable.
- States: IDLE, PUSH, POP, POP_WAIT, DONE, FAIL.
- IDLE, req=1 (opcode decoded here):
  - CALL (opcode[15:12]=4'h2), depth<DEPTH: latch target=opcode[11:0] and ret=pc_in+2 (mod 2^PC_W, so 12'hFFE -> 12'h000); go to PUSH.
  - CALL, depth==DEPTH: set err_overflow; go to FAIL.
  - RET (opcode==16'h00EE), depth>0: go to POP.
  - RET, depth==0: set err_underflow; go to FAIL.
  - Any other opcode: go to FAIL; sticky flags unchanged.
- PUSH: stk_we=01; stk_wdata=zero-extended ret; depth+1; go to DONE with pc_next=target.
- POP: stk_we=10; depth-1; go to POP_WAIT.
- POP_WAIT: stk_we=00; capture pc_next=stk_rdata[PC_W-1:0] (the stack presents the popped value the cycle after the pop strobe); go to DONE.
- DONE: done=1; pc_load=1; go to IDLE.
- FAIL: done=1; err=1; pc_load=0; stack untouched; go to IDLE.
- Latency from the req-accept edge to the done cycle: CALL 2 cycles, RET 3 cycles, FAIL 1 cycle. Back-to-back requests are allowed: a req on the first IDLE cycle after DONE is accepted.
- stk_we is a Moore decode of state and is never 11. At most one stack strobe is issued per request.
- req while ready=0 is ignored; nothing is queued.
- err_clear in the same cycle as a new overflow/underflow event: the set wins.
- stk_wdata holds its last value when stk_we=00.
- Reset mid-operation (e.g. in PUSH) aborts at once. No done pulse is issued, and depth returns to 0 even if a push already completed.

Decomposition:
- Package chip8_stack_pkg holds:
  - enum state_t with the six states;
  - constants STK_NOP=2'b00, STK_PUSH=2'b01, STK_POP=2'b10;
  - OP_RET=16'h00EE, OP_CALL_NIB=4'h2.
- Chip8_Stack will import the same WE constants.
- One sub-module, chip8_stack_depth_ctr: up/down counter with full/empty outputs, parameterised by DEPTH, async reset.

Test Plan:
- CALL at reset: pc_in=12'h200, opcode=16'h2345, req 1 cycle -> next cycle stk_we=01 and stk_wdata=16'h0202; following cycle done=pc_load=1, pc_next=12'h345, depth=1.
- CALL then RET: after the above, pc_in=12'h350, opcode=16'h00EE -> stk_we=10 for one cycle; 2 cycles later done=pc_load=1, pc_next=12'h202, depth=0.
- Nested 3 CALLs (ret 0x202, 0x346, 0x402) then 3 RETs -> pc_next sequence 0x402, 0x346, 0x202; depth 3 then back to 0.
- Boundary: 16 CALLs give depth=16; a 17th CALL -> done=err=1, err_overflow=1, no push strobe, depth stays 16. Likewise RET at depth 0 -> err_underflow=1, no pop strobe. err_clear -> both flags 0.
- Wrap and invalid opcode: CALL with pc_in=12'hFFE -> stk_wdata=16'h0000. opcode=16'h1234 -> done=err=1 after 1 cycle, flags unchanged, stk_we stays 00.
- Reset mid-op: assert reset during PUSH -> stk_we=00, depth=0, ready=1 in the same cycle; no done pulse. A following RET -> err_underflow.
